// File: rtl/display_spi_scheduler_if.sv
// Host write port of the display SPI scheduler: one register write per accepted cycle.
// Signal suffixes are from the scheduler's point of view.
interface display_spi_scheduler_if;
    logic       wr_valid_i;
    logic       wr_ready_o;
    logic [3:0] wr_addr_i;
    logic [7:0] wr_data_i;
    logic       wr_err_o;

    modport master (
        output wr_valid_i,
        output wr_addr_i,
        output wr_data_i,
        input  wr_ready_o,
        input  wr_err_o
    );

    modport slave (
        input  wr_valid_i,
        input  wr_addr_i,
        input  wr_data_i,
        output wr_ready_o,
        output wr_err_o
    );
endinterface

// File: rtl/display_spi_scheduler.sv
// Shadow register file with dirty bits, drained round-robin as 16-bit SPI frames.
// Optional periodic full resync is enabled by defining DISPLAY_AUTO_REFRESH_EN.
module display_spi_scheduler #(
    parameter int unsigned NUM_REGS       = 10,
    parameter int unsigned CLK_DIV        = 4,
    parameter int unsigned GAP_CYCLES     = 4
`ifdef DISPLAY_AUTO_REFRESH_EN
    , parameter int unsigned REFRESH_PERIOD = 1 << 20
`endif
) (
    input  logic                     block_clk_i,
    input  logic                     rst_i,
    display_spi_scheduler_if.slave   host_io,
    input  logic                     sync_all_i,
    output logic                     busy_o,
    output logic                     spi_sclk_o,
    output logic                     spi_ss_o,
    output logic                     spi_mosi_o
);

    localparam int unsigned IdxW = 4;
    localparam int unsigned DivW = $clog2(CLK_DIV);
    localparam int unsigned GapW = $clog2(GAP_CYCLES);

    typedef enum logic [1:0] {StIdle, StSelect, StShift, StGap} state_e;

    state_e              state_q;
    logic [7:0]          shadow_q [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_q, dirty_d;
    logic [IdxW-1:0]     rr_ptr_q;
    logic [15:0]         shift_q;
    logic [DivW-1:0]     div_q;
    logic [4:0]          bit_q;
    logic [GapW-1:0]     gap_q;
    logic                sclk_q, ss_q, mosi_q, busy_q, wr_err_q;

    logic                wr_fire, addr_ok, refresh_hit, sel_found;
    logic [IdxW-1:0]     sel_idx, cand;
    logic [15:0]         frame;

    assign wr_fire = host_io.wr_valid_i & host_io.wr_ready_o;
    assign addr_ok = 32'(host_io.wr_addr_i) < NUM_REGS;

`ifdef DISPLAY_AUTO_REFRESH_EN
    logic [31:0] refresh_q;

    assign refresh_hit = refresh_q == 32'(REFRESH_PERIOD - 1);

    always_ff @(posedge block_clk_i) begin
        if (rst_i || refresh_hit) refresh_q <= '0;
        else                      refresh_q <= refresh_q + 32'd1;
    end
`else
    assign refresh_hit = 1'b0;
`endif

    // First dirty index strictly after rr_ptr_q, wrapping at NUM_REGS.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_ptr_q;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REGS; i++) begin
            cand = IdxW'((32'(rr_ptr_q) + i) % NUM_REGS);
            if (!sel_found && dirty_q[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign frame = {4'b0001, sel_idx, shadow_q[sel_idx]};

    // A set on the same edge as the SELECT clear wins, so the register is resent.
    always_comb begin
        dirty_d = dirty_q;
        if (state_q == StSelect && sel_found) dirty_d[sel_idx] = 1'b0;
        if (wr_fire && addr_ok) dirty_d[host_io.wr_addr_i] = 1'b1;
        if (sync_all_i || refresh_hit) dirty_d = '1;
    end

    always_ff @(posedge block_clk_i) begin
        if (rst_i) begin
            shadow_q <= '{default: '0};
            dirty_q  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            if (wr_fire && addr_ok) shadow_q[host_io.wr_addr_i] <= host_io.wr_data_i;
            dirty_q  <= dirty_d;
            wr_err_q <= wr_fire & ~addr_ok;
        end
    end

    always_ff @(posedge block_clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            rr_ptr_q <= IdxW'(NUM_REGS - 1);
            shift_q  <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
            sclk_q   <= 1'b1;
            ss_q     <= 1'b1;
            mosi_q   <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|dirty_q) begin
                        state_q <= StSelect;
                        busy_q  <= 1'b1;
                    end
                end
                StSelect: begin
                    rr_ptr_q <= sel_idx;
                    shift_q  <= frame;
                    mosi_q   <= frame[15];
                    ss_q     <= 1'b0;
                    div_q    <= DivW'(CLK_DIV - 1);
                    bit_q    <= '0;
                    state_q  <= StShift;
                end
                StShift: begin
                    if (div_q == DivW'(CLK_DIV - 1)) begin
                        div_q <= '0;
                        if (sclk_q) begin
                            if (bit_q == 5'd16) begin
                                state_q <= StGap;
                                ss_q    <= 1'b1;
                                mosi_q  <= 1'b1;
                                gap_q   <= '0;
                            end else begin
                                sclk_q <= 1'b0;
                                // Bit 15 was presented in SELECT; later falls advance the data.
                                if (bit_q != 5'd0) begin
                                    mosi_q  <= shift_q[14];
                                    shift_q <= {shift_q[14:0], 1'b0};
                                end
                            end
                        end else begin
                            sclk_q <= 1'b1;
                            bit_q  <= bit_q + 5'd1;
                        end
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
                StGap: begin
                    // SELECT is the last SS-high cycle, so the gap state itself is one shorter.
                    if (gap_q == GapW'(GAP_CYCLES - 2)) begin
                        if (|dirty_q) begin
                            state_q <= StSelect;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign host_io.wr_ready_o = ~rst_i;
    assign host_io.wr_err_o   = wr_err_q;
    assign busy_o             = busy_q;
    assign spi_sclk_o         = sclk_q;
    assign spi_ss_o           = ss_q;
    assign spi_mosi_o         = mosi_q;

endmodule
